// File: rtl/rr_arb_32_idx.sv
// Round-robin arbiter for 32 requesters producing a registered 5-bit grant index.
// The index is offered with valid/ready and then held through a busy phase until the client reports done.
module rr_arb_32_idx #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          gnt_ready,
    input  logic          done,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_e;

    state_e        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gntIdx_q;
    logic          gntValid_q;
    logic          busy_q;
    logic [IW-1:0] searchIdx_d;
    logic [IW-1:0] candIdx;

    // Scan from ptr back down to ptr+1 so the last hit written is the one
    // closest after ptr; i = N wraps to ptr itself, the lowest priority.
    always_comb begin
        searchIdx_d = gntIdx_q;
        candIdx     = '0;
        for (int i = N; i >= 1; i--) begin
            candIdx = ptr_q + IW'(i);
            if (req[candIdx]) begin
                searchIdx_d = candIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(N - 1);
            gntIdx_q   <= '0;
            gntValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gntIdx_q   <= searchIdx_d;
                        gntValid_q <= 1'b1;
                        state_q    <= OFFER;
                    end
                end
                // Acceptance takes precedence over a withdrawal seen in the same cycle.
                OFFER: begin
                    if (gnt_ready) begin
                        gntValid_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ptr_q      <= gntIdx_q;
                        state_q    <= BUSY;
                    end else if (!req[gntIdx_q]) begin
                        gntValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                BUSY: begin
                    if (done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gntValid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign gnt_valid = gntValid_q;
    assign gnt_idx   = gntIdx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arb_32_idx.sv
// Directed bench for rr_arb_32_idx: reset, single grant, rotation, wrap,
// withdrawal, ready-vs-withdraw race, back-pressure and async reset mid-grant.
module tb_rr_arb_32_idx;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        gnt_ready;
    logic        done;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic        busy;

    int checks;
    int errors;

    rr_arb_32_idx #(.N(32), .IW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt_ready (gnt_ready),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1ns after the next rising edge, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        req       = '0;
        gnt_ready = 1'b0;
        done      = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", gnt_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
        end
        checks++;
        if (gnt_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_idx: got %0d expected 0", gnt_idx);
        end
    endtask

    task automatic test_single();
        doReset();
        req = 32'h0000_0020;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd5) begin
            errors++;
            $display("[TB] FAIL single_offer: got valid=%0b idx=%0d expected valid=1 idx=5", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || gnt_valid !== 1'b0 || gnt_idx !== 5'd5) begin
            errors++;
            $display("[TB] FAIL single_accept: got busy=%0b valid=%0b idx=%0d expected busy=1 valid=0 idx=5", busy, gnt_valid, gnt_idx);
        end
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_hold_busy: got %0b expected 1", busy);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (busy !== 1'b0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_release: got busy=%0b valid=%0b expected busy=0 valid=0", busy, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        logic [4:0] expIdx;
        doReset();
        req       = 32'hFFFF_FFFF;
        gnt_ready = 1'b1;
        for (int g = 0; g < 33; g++) begin
            expIdx = 5'(g % 32);
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== expIdx) begin
                errors++;
                $display("[TB] FAIL rotation_offer[%0d]: got valid=%0b idx=%0d expected valid=1 idx=%0d", g, gnt_valid, gnt_idx, expIdx);
            end
            tick();
            checks++;
            if (busy !== 1'b1 || gnt_idx !== expIdx) begin
                errors++;
                $display("[TB] FAIL rotation_busy[%0d]: got busy=%0b idx=%0d expected busy=1 idx=%0d", g, busy, gnt_idx, expIdx);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        gnt_ready = 1'b0;
    endtask

    task automatic test_wrap();
        doReset();
        req       = 32'h4000_0000;
        gnt_ready = 1'b1;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 32'h8000_0001;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd31) begin
            errors++;
            $display("[TB] FAIL wrap_first: got valid=%0b idx=%0d expected valid=1 idx=31", gnt_valid, gnt_idx);
        end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL wrap_second: got valid=%0b idx=%0d expected valid=1 idx=0", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b0;
    endtask

    task automatic test_withdrawal();
        doReset();
        req = 32'h0000_1080;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd7) begin
            errors++;
            $display("[TB] FAIL withdraw_offer7: got valid=%0b idx=%0d expected valid=1 idx=7", gnt_valid, gnt_idx);
        end
        req = 32'h0000_1000;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL withdraw_drop: got valid=%0b busy=%0b expected valid=0 busy=0", gnt_valid, busy);
        end
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd12) begin
            errors++;
            $display("[TB] FAIL withdraw_offer12: got valid=%0b idx=%0d expected valid=1 idx=12", gnt_valid, gnt_idx);
        end
        // Withdraw again; with ptr still 31 the search starts at 0 and finds 3 before 13.
        req = 32'h0000_2008;
        tick();
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd3) begin
            errors++;
            $display("[TB] FAIL withdraw_ptr_kept: got valid=%0b idx=%0d expected valid=1 idx=3", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_ready_and_withdraw();
        doReset();
        req = 32'h0000_0028;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd3) begin
            errors++;
            $display("[TB] FAIL race_offer: got valid=%0b idx=%0d expected valid=1 idx=3", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b1;
        req       = 32'h0000_0020;
        tick();
        gnt_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || gnt_valid !== 1'b0 || gnt_idx !== 5'd3) begin
            errors++;
            $display("[TB] FAIL race_accept: got busy=%0b valid=%0b idx=%0d expected busy=1 valid=0 idx=3", busy, gnt_valid, gnt_idx);
        end
        req  = 32'h0000_000A;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd1) begin
            errors++;
            $display("[TB] FAIL race_next_not3: got valid=%0b idx=%0d expected valid=1 idx=1", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_backpressure();
        doReset();
        gnt_ready = 1'b1;
        done      = 1'b1;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignores: got valid=%0b busy=%0b expected valid=0 busy=0", gnt_valid, busy);
        end
        gnt_ready = 1'b0;
        req       = 32'h0010_0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            req = 32'h0010_0000 | (32'h1 << c);
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 5'd20 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: got valid=%0b idx=%0d busy=%0b expected valid=1 idx=20 busy=0", c, gnt_valid, gnt_idx, busy);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_async_reset();
        doReset();
        req = 32'h0000_0200;
        tick();
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || gnt_idx !== 5'd9) begin
            errors++;
            $display("[TB] FAIL areset_setup: got busy=%0b idx=%0d expected busy=1 idx=9", busy, gnt_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got valid=%0b busy=%0b idx=%0d expected valid=0 busy=0 idx=0", gnt_valid, busy, gnt_idx);
        end
        req = 32'hFFFF_FFFF;
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 5'd0) begin
            errors++;
            $display("[TB] FAIL areset_first_offer: got valid=%0b idx=%0d expected valid=1 idx=0", gnt_valid, gnt_idx);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = '0;
        gnt_ready = 1'b0;
        done      = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_withdrawal();
        test_ready_and_withdraw();
        test_backpressure();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
